// File: rtl/sub16_if.sv
// sub16_if: operand/result handshake bundle for sub16_pipe.
//   in_valid/in_ready  : operand transfer (A, B, BIN)
//   out_valid/out_ready: result transfer (D, BOUT, OVF, Z)
//   master modport = producer/consumer side, slave modport = subtractor side.
interface sub16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        BIN;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        BOUT;
    logic        OVF;
    logic        Z;

    modport master (
        output in_valid, A, B, BIN, out_ready,
        input  in_ready, out_valid, D, BOUT, OVF, Z
    );

    modport slave (
        input  in_valid, A, B, BIN, out_ready,
        output in_ready, out_valid, D, BOUT, OVF, Z
    );
endinterface

// File: rtl/sub16_pipe.sv
// sub16_pipe: two-stage pipelined 16-bit subtractor, D = A - B - BIN.
// Computed as A + ~B + ~BIN with 4-bit generate/propagate lookahead groups.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards all in-flight work
//   bus   : sub16_if.slave -- operands in (in_valid/in_ready, A, B, BIN),
//           results out (out_valid/out_ready, D, BOUT, OVF, Z)
// Stage 1 resolves the low byte and the carry into bit 8; stage 2 resolves
// the high byte and flags into the output register. Capacity: 2 results.
module sub16_pipe (
    input logic   clk,
    input logic   rst_n,
    sub16_if.slave bus
);

    // Carry into each bit of a 4-bit group, fully lookahead-expanded.
    function automatic logic [3:0] grp_carries(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       cin);
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic grp_prop(input logic [3:0] p);
        return &p;
    endfunction

    // Stage 1 registers
    logic       s1_valid;
    logic [7:0] s1_dlo;
    logic       s1_c8;
    logic [7:0] s1_ahi;   // bit 7 is A[15]
    logic [7:0] s1_bhi;   // bit 7 is B[15]

    // Output registers
    logic        out_valid_q;
    logic [15:0] d_q;
    logic        bout_q;
    logic        ovf_q;
    logic        z_q;

    // Flow control
    logic adv2;
    logic accept;

    always_comb begin
        adv2   = s1_valid && (!out_valid_q || bus.out_ready);
        accept = bus.in_valid && (!s1_valid || adv2);
    end

    assign bus.in_ready  = !s1_valid || adv2;
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;
    assign bus.BOUT      = bout_q;
    assign bus.OVF       = ovf_q;
    assign bus.Z         = z_q;

    // Stage 1 combinational: low byte and c8
    logic [7:0] lo_nb, lo_g, lo_p, lo_dif;
    logic       c0, c4, c8;
    logic       lg0, lp0, lg1, lp1;

    always_comb begin
        lo_nb  = ~bus.B[7:0];
        lo_g   = bus.A[7:0] & lo_nb;
        lo_p   = bus.A[7:0] | lo_nb;
        c0     = ~bus.BIN;
        lg0    = grp_gen(lo_g[3:0], lo_p[3:0]);
        lp0    = grp_prop(lo_p[3:0]);
        lg1    = grp_gen(lo_g[7:4], lo_p[7:4]);
        lp1    = grp_prop(lo_p[7:4]);
        c4     = lg0 | (lp0 & c0);
        c8     = lg1 | (lp1 & lg0) | (lp1 & lp0 & c0);
        lo_dif = (bus.A[7:0] ^ lo_nb)
               ^ {grp_carries(lo_g[7:4], lo_p[7:4], c4),
                  grp_carries(lo_g[3:0], lo_p[3:0], c0)};
    end

    // Stage 2 combinational: high byte, c16 and flags
    logic [7:0]  hi_nb, hi_g, hi_p, hi_dif;
    logic        c12, c16;
    logic        hg0, hp0, hg1, hp1;
    logic [15:0] d_full;

    always_comb begin
        hi_nb  = ~s1_bhi;
        hi_g   = s1_ahi & hi_nb;
        hi_p   = s1_ahi | hi_nb;
        hg0    = grp_gen(hi_g[3:0], hi_p[3:0]);
        hp0    = grp_prop(hi_p[3:0]);
        hg1    = grp_gen(hi_g[7:4], hi_p[7:4]);
        hp1    = grp_prop(hi_p[7:4]);
        c12    = hg0 | (hp0 & s1_c8);
        c16    = hg1 | (hp1 & hg0) | (hp1 & hp0 & s1_c8);
        hi_dif = (s1_ahi ^ hi_nb)
               ^ {grp_carries(hi_g[7:4], hi_p[7:4], c12),
                  grp_carries(hi_g[3:0], hi_p[3:0], s1_c8)};
        d_full = {hi_dif, s1_dlo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_dlo   <= '0;
            s1_c8    <= 1'b0;
            s1_ahi   <= '0;
            s1_bhi   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_dlo   <= lo_dif;
            s1_c8    <= c8;
            s1_ahi   <= bus.A[15:8];
            s1_bhi   <= bus.B[15:8];
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // Data only moves on adv2, so a stalled result stays bit-stable and a
    // drained one keeps its last value with out_valid low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            z_q         <= 1'b0;
        end else if (adv2) begin
            out_valid_q <= 1'b1;
            d_q         <= d_full;
            bout_q      <= ~c16;
            ovf_q       <= (s1_ahi[7] ^ s1_bhi[7]) & (hi_dif[7] ^ s1_ahi[7]);
            z_q         <= (d_full == '0);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sub16_pipe.sv
// tb_sub16_pipe: self-checking bench for sub16_pipe. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the falling edge.
module tb_sub16_pipe;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sub16_if bus ();

    sub16_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: {BOUT, OVF, Z, D} from plain wide arithmetic.
    function automatic logic [18:0] ref_sub(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic        bin);
        logic [16:0] diff;
        logic [15:0] d;
        logic        ovf;
        diff = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        d    = diff[15:0];
        ovf  = (a[15] != b[15]) && (d[15] != a[15]);
        return {diff[16], ovf, (d == 16'd0), d};
    endfunction

    function automatic logic [18:0] dut_res();
        return {bus.BOUT, bus.OVF, bus.Z, bus.D};
    endfunction

    task automatic drive(input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic bin);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.BIN      = bin;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || dut_res() !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b res=%h expected 0/0", bus.out_valid, dut_res());
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [6] = '{16'h1234, 16'h0100, 16'h0000, 16'h8000, 16'h00FF, 16'h5555};
        logic [15:0] tb [6] = '{16'h0234, 16'h0001, 16'h0001, 16'h0001, 16'h00FF, 16'h5555};
        logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [18:0] exp;
        for (int i = 0; i < 6; i++) begin
            exp = ref_sub(ta[i], tb[i], tc[i]);
            @(negedge clk);
            bus.out_ready = 1'b1;
            drive(1'b1, ta[i], tb[i], tc[i]);
            @(negedge clk);                 // edge N accepted the op
            drive(1'b0, 16'h0, 16'h0, 1'b0);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_early_valid: out_valid=%b expected 0", i, bus.out_valid);
            end
            @(negedge clk); #1;             // after edge N+1
            checks++;
            if (bus.out_valid !== 1'b1 || dut_res() !== exp) begin
                errors++;
                $display("FAIL dir%0d_result: valid=%b res=%h expected 1/%h", i, bus.out_valid, dut_res(), exp);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dir_drain: out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] e1, e2, e3;
        e1 = ref_sub(16'h0003, 16'h0005, 1'b0);
        e2 = ref_sub(16'h7FFF, 16'hFFFF, 1'b1);
        e3 = ref_sub(16'hABCD, 16'h1234, 1'b1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0003, 16'h0005, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_op1_ready: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
        drive(1'b1, 16'h7FFF, 16'hFFFF, 1'b1);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_op2_ready: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
        drive(1'b1, 16'hABCD, 16'h1234, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || dut_res() !== e1) begin
                errors++;
                $display("FAIL bp_stall%0d: in_ready=%b valid=%b res=%h expected 0/1/%h", k, bus.in_ready, bus.out_valid, dut_res(), e1);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || dut_res() !== e1) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b res=%h expected 1/%h", bus.in_ready, dut_res(), e1);
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || dut_res() !== e2) begin
            errors++;
            $display("FAIL bp_order2: valid=%b res=%h expected 1/%h", bus.out_valid, dut_res(), e2);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || dut_res() !== e3) begin
            errors++;
            $display("FAIL bp_order3: valid=%b res=%h expected 1/%h", bus.out_valid, dut_res(), e3);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_throughput();
        logic [15:0] a [16];
        logic [15:0] b [16];
        logic        c [16];
        logic [18:0] exp;
        for (int i = 0; i < 16; i++) begin
            a[i] = 16'($urandom);
            b[i] = 16'($urandom);
            c[i] = 1'($urandom);
        end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            @(negedge clk);
            if (cyc < 16) drive(1'b1, a[cyc], b[cyc], c[cyc]);
            else          drive(1'b0, 16'h0, 16'h0, 1'b0);
            #1;
            if (cyc < 16) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL tp_ready%0d: got %b expected 1", cyc, bus.in_ready);
                end
            end
            if (cyc >= 2) begin
                exp = ref_sub(a[cyc-2], b[cyc-2], c[cyc-2]);
                checks++;
                if (bus.out_valid !== 1'b1 || dut_res() !== exp) begin
                    errors++;
                    $display("FAIL tp_out%0d: valid=%b res=%h expected 1/%h", cyc - 2, bus.out_valid, dut_res(), exp);
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL tp_drain: out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0000, 16'h0001, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h8000, 16'h0001, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || dut_res() !== ref_sub(16'h0000, 16'h0001, 1'b0)) begin
            errors++;
            $display("FAIL rm_prefill: valid=%b res=%h expected 1/%h", bus.out_valid, dut_res(), ref_sub(16'h0000, 16'h0001, 1'b0));
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || dut_res() !== 19'd0) begin
            errors++;
            $display("FAIL rm_async_clear: valid=%b res=%h expected 0/0", bus.out_valid, dut_res());
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rm_in_ready: got %b expected 1", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rm_stale%0d: out_valid=%b expected 0", k, bus.out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [18:0] q[$];
        logic [18:0] exp;
        logic [18:0] prev_res;
        logic        prev_stall;
        int          sent;
        int          cyc;
        sent       = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_res   = '0;
        while ((sent < 2000 || q.size() > 0) && cyc < 30000) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 2000 && $urandom_range(0, 9) < 7)
                drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            else
                drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
            #1;
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || dut_res() !== prev_res) begin
                    errors++;
                    $display("FAIL rnd_stall_hold: valid=%b res=%h expected 1/%h", bus.out_valid, dut_res(), prev_res);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious: res=%h with nothing outstanding", dut_res());
                end else begin
                    exp = q.pop_front();
                    if (dut_res() !== exp) begin
                        errors++;
                        $display("FAIL rnd_result: res=%h expected %h", dut_res(), exp);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                q.push_back(ref_sub(bus.A, bus.B, bus.BIN));
                sent++;
            end
            prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
            prev_res   = dut_res();
            cyc++;
        end
        checks++;
        if (sent != 2000 || q.size() != 0) begin
            errors++;
            $display("FAIL rnd_timeout: sent=%0d outstanding=%0d expected 2000/0", sent, q.size());
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
